// File: rtl/mult_exhaustive_checker_if.sv
// Operand/product and result bundle between the exhaustive multiplier checker
// and its environment.
interface mult_exhaustive_checker_if #(
  parameter int WIDTH = 2
);
  logic                 start;
  logic [WIDTH-1:0]     mult_a;
  logic [WIDTH-1:0]     mult_b;
  logic [2*WIDTH-1:0]   mult_p;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [2*WIDTH:0]     err_count;
  logic [WIDTH-1:0]     first_err_a;
  logic [WIDTH-1:0]     first_err_b;
  logic [2*WIDTH-1:0]   first_err_p;
  logic                 first_err_valid;

  modport master (
    output start, mult_p,
    input  mult_a, mult_b, busy, done, pass, err_count,
           first_err_a, first_err_b, first_err_p, first_err_valid
  );

  modport slave (
    input  start, mult_p,
    output mult_a, mult_b, busy, done, pass, err_count,
           first_err_a, first_err_b, first_err_p, first_err_valid
  );
endinterface

// File: rtl/mult_exhaustive_checker.sv
// Sweeps every {A,B} pair through a multiplier under test and scores its products.
// Optional first-mismatch capture: define MULT_CHK_FIRST_ERR_EN.
module mult_exhaustive_checker #(
  parameter int WIDTH   = 2,
  parameter int DUT_LAT = 0
) (
  input logic                      clk,
  input logic                      rst_n,
  mult_exhaustive_checker_if.slave chk
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(DUT_LAT + 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_idx;
  logic [CW-1:0]   r_drain_cnt;
  logic [PW:0]     r_err;
  logic            r_pass, r_busy, r_done;
  logic            w_last, w_start_acc;
  logic [PW-1:0]   w_cmp_idx, w_cmp_exp, w_err_inc;
  logic            w_cmp_vld, w_mis;
  logic [PW:0]     w_err_nxt;

  assign w_last      = &r_idx;
  assign w_start_acc = (r_state == S_IDLE) && chk.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (chk.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = (DUT_LAT > 0) ? S_DRAIN : S_DONE;
      S_DRAIN: if (r_drain_cnt == DRAIN_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // idx stops on all-ones so the operands hold the last vector after RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_start_acc)                   r_idx <= '0;
      else if (r_state == S_RUN && !w_last) r_idx <= r_idx + 1'b1;
      r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
    end
  end

  assign chk.mult_a = r_idx[PW-1:WIDTH];
  assign chk.mult_b = r_idx[WIDTH-1:0];

  // Delay the vector itself; the reference product is formed at the compare point.
  generate
    if (DUT_LAT == 0) begin : g_wire
      assign w_cmp_idx = r_idx;
      assign w_cmp_vld = (r_state == S_RUN);
    end else begin : g_pipe
      logic [DUT_LAT:1]         r_vld_pipe;
      logic [DUT_LAT:1][PW-1:0] r_idx_pipe;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_pipe <= '0;
          r_idx_pipe <= '0;
        end else begin
          r_vld_pipe[1] <= (r_state == S_RUN);
          r_idx_pipe[1] <= r_idx;
          for (int i = 2; i <= DUT_LAT; i++) begin
            r_vld_pipe[i] <= r_vld_pipe[i-1];
            r_idx_pipe[i] <= r_idx_pipe[i-1];
          end
        end
      end
      assign w_cmp_idx = r_idx_pipe[DUT_LAT];
      assign w_cmp_vld = r_vld_pipe[DUT_LAT];
    end
  endgenerate

  assign w_cmp_exp = {{WIDTH{1'b0}}, w_cmp_idx[PW-1:WIDTH]} * {{WIDTH{1'b0}}, w_cmp_idx[WIDTH-1:0]};
  assign w_mis     = w_cmp_vld && (chk.mult_p != w_cmp_exp);
  assign w_err_inc = {{(PW-1){1'b0}}, w_mis};
  assign w_err_nxt = r_err + {1'b0, w_err_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= '0;
      r_pass <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (r_state == S_RUN) || (r_state == S_DRAIN);
      r_done <= (r_state == S_DONE);
      if (w_start_acc) begin
        r_err  <= '0;
        r_pass <= 1'b0;
      end else begin
        r_err <= w_err_nxt;
        if (r_state == S_DONE) r_pass <= (w_err_nxt == '0);
      end
    end
  end

  assign chk.busy      = r_busy;
  assign chk.done      = r_done;
  assign chk.pass      = r_pass;
  assign chk.err_count = r_err;

`ifdef MULT_CHK_FIRST_ERR_EN
  logic [WIDTH-1:0] r_fe_a, r_fe_b;
  logic [PW-1:0]    r_fe_p;
  logic             r_fe_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fe_a     <= '0;
      r_fe_b     <= '0;
      r_fe_p     <= '0;
      r_fe_valid <= 1'b0;
    end else if (w_start_acc) begin
      r_fe_a     <= '0;
      r_fe_b     <= '0;
      r_fe_p     <= '0;
      r_fe_valid <= 1'b0;
    end else if (w_mis && !r_fe_valid) begin
      r_fe_a     <= w_cmp_idx[PW-1:WIDTH];
      r_fe_b     <= w_cmp_idx[WIDTH-1:0];
      r_fe_p     <= chk.mult_p;
      r_fe_valid <= 1'b1;
    end
  end
  assign chk.first_err_a     = r_fe_a;
  assign chk.first_err_b     = r_fe_b;
  assign chk.first_err_p     = r_fe_p;
  assign chk.first_err_valid = r_fe_valid;
`else
  assign chk.first_err_a     = '0;
  assign chk.first_err_b     = '0;
  assign chk.first_err_p     = '0;
  assign chk.first_err_valid = 1'b0;
`endif
endmodule

// File: tb/tb_mult_exhaustive_checker.sv
// Scoreboard bench: a behavioural multiplier (optionally faulty or mis-pipelined)
// feeds the checker; predicted sweep results are queued and popped on done.
module tb_mult_exhaustive_checker;
  localparam int WIDTH   = 2;
  localparam int DUT_LAT = 2;
  localparam int PW      = 2 * WIDTH;
  localparam int N       = 1 << PW;
  localparam int MSK     = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_exhaustive_checker_if #(.WIDTH(WIDTH)) bus ();
  mult_exhaustive_checker #(.WIDTH(WIDTH), .DUT_LAT(DUT_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .chk(bus)
  );

  typedef struct {
    int err; int pass; int fev; int fa; int fb; int fp; int done_cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0, fails = 0, cyc = 0, done_seen = 0, busy_cnt = 0;
  bit   prev_done = 1'b0;
  int   mode = 0, tb_lat = DUT_LAT;
  bit   flip_mask [N];

  // multiplier under test: 0 golden, 1 stuck at zero, 2 wrong at max*max, 3 random lsb flips
  function automatic logic [PW-1:0] mul_model(int m, int a, int b);
    int p;
    p = a * b;
    case (m)
      1: p = 0;
      2: if (a == MSK && b == MSK) p = 8;
      3: if (flip_mask[a * (MSK + 1) + b]) p = p ^ 1;
      default: ;
    endcase
    return PW'(p);
  endfunction

  logic [PW-1:0] p_comb;
  logic [PW-1:0] pipe [DUT_LAT];
  always_comb p_comb = mul_model(mode, int'(bus.mult_a), int'(bus.mult_b));
  always @(posedge clk) begin
    pipe[0] <= p_comb;
    for (int i = 1; i < DUT_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mult_p = (tb_lat == 0) ? p_comb : pipe[DUT_LAT-1];

  always @(posedge clk) cyc++;

  task automatic chk(string nm, longint act, longint req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Whole-sweep reference: the product seen when vector k is scored comes from
  // vector k+skew (clamped to the last one, since operands hold after RUN).
  function automatic exp_t predict(int m, int lat, int e0);
    exp_t e;
    int j, seen, want;
    e = '{default: 0};
    for (int k = 0; k < N; k++) begin
      j    = (k + DUT_LAT - lat > N - 1) ? N - 1 : k + DUT_LAT - lat;
      seen = int'(mul_model(m, j >> WIDTH, j & MSK));
      want = (k >> WIDTH) * (k & MSK);
      if (seen != want) begin
        e.err++;
        if (e.fev == 0) begin
          e.fev = 1; e.fa = k >> WIDTH; e.fb = k & MSK; e.fp = seen;
        end
      end
    end
`ifndef MULT_CHK_FIRST_ERR_EN
    e.fev = 0; e.fa = 0; e.fb = 0; e.fp = 0;
`endif
    e.pass     = (e.err == 0) ? 1 : 0;
    e.done_cyc = e0 + N + DUT_LAT + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("done_pulse_width", bus.done, 0);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        chk("done_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          chk("done_cycle", cyc, mon_e.done_cyc);
          chk("busy_cycles", busy_cnt, N + DUT_LAT);
          chk("err_count", bus.err_count, mon_e.err);
          chk("pass", bus.pass, mon_e.pass);
          chk("first_err_valid", bus.first_err_valid, mon_e.fev);
          chk("first_err_a", bus.first_err_a, mon_e.fa);
          chk("first_err_b", bus.first_err_b, mon_e.fb);
          chk("first_err_p", bus.first_err_p, mon_e.fp);
        end
        busy_cnt = 0;
        done_seen++;
      end
      prev_done = bus.done;
    end
  end

  task automatic check_zero(string tag);
    chk({tag, "_mult_a"}, bus.mult_a, 0);
    chk({tag, "_mult_b"}, bus.mult_b, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_err_count"}, bus.err_count, 0);
    chk({tag, "_first_err_valid"}, bus.first_err_valid, 0);
    chk({tag, "_first_err_p"}, bus.first_err_p, 0);
  endtask

  // abort_at >= 0: assert reset while vector abort_at is driven.
  // restart: extra start pulses at vector 5 and in the DONE cycle, then a hold check.
  task automatic run_sweep(int m, int lat, int abort_at, bit restart);
    int   e0, d0;
    exp_t pe;
    mode   = m;
    tb_lat = lat;
    @(negedge clk);
    bus.start = 1'b1;
    e0 = cyc + 1;
    d0 = done_seen;
    pe = predict(m, lat, e0);
    q.push_back(pe);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.start = restart && (k == 5);
      chk("vector_order", {bus.mult_a, bus.mult_b}, k);
      if (k == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        void'(q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + DUT_LAT + 4) @(negedge clk);
        chk("no_done_after_abort", done_seen, d0);
        chk("idle_after_abort", bus.busy, 0);
        return;
      end
    end
    repeat (DUT_LAT + 1) @(negedge clk);
    bus.start = restart;
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 40 && done_seen == d0; t++) @(negedge clk);
    chk("done_within_budget", done_seen > d0, 1);
    chk("operands_hold", {bus.mult_a, bus.mult_b}, N - 1);
    if (restart) begin
      repeat (10) @(negedge clk);
      chk("hold_err_count", bus.err_count, pe.err);
      chk("hold_pass", bus.pass, pe.pass);
      chk("hold_idle", bus.busy, 0);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) flip_mask[i] = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_sweep(0, DUT_LAT, -1, 1'b0);  // golden
    run_sweep(1, DUT_LAT, -1, 1'b0);  // stuck at zero
    run_sweep(0, 0, -1, 1'b0);        // golden but latency shorter than declared
    run_sweep(0, DUT_LAT, 7, 1'b0);   // reset mid-sweep
    run_sweep(0, DUT_LAT, -1, 1'b0);
    run_sweep(0, DUT_LAT, -1, 1'b1);  // ignored restarts, then hold
    run_sweep(2, DUT_LAT, -1, 1'b0);  // single wrong product
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) flip_mask[i] = ($urandom_range(0, 3) == 0);
      run_sweep(3, DUT_LAT, -1, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
